// File: rtl/phoenix_led_sequencer.sv
// Multi-channel LED sequencer: per-channel OFF/ON/BLINK/BREATHE duty words for the
// downstream PWM generators, reconfigured at run time through a valid/ready command port.
module phoenix_led_sequencer #(
  parameter int unsigned CLOCK_FREQUENCY  = 25_000_000,
  parameter int unsigned PWM_COUNTER_BITS = 32,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned PWM_CYCLE        = CLOCK_FREQUENCY / 1000,
  parameter int unsigned BLINK_CYCLE      = CLOCK_FREQUENCY,
  parameter int unsigned BLINK_ON_COUNT   = CLOCK_FREQUENCY / 2,
  parameter int unsigned BREATHE_TICK     = CLOCK_FREQUENCY / 1000,
  parameter int unsigned BREATHE_STEP     = PWM_CYCLE / 500,
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [CW-1:0]                    cmd_channel,
  input  logic [1:0]                       cmd_mode,
  input  logic [PWM_COUNTER_BITS-1:0]      cmd_level,
  output logic                             cmd_error,
  output logic [PWM_COUNTER_BITS-1:0]      pwm_cycle,
  output logic [CHANNELS*PWM_COUNTER_BITS-1:0] pwm_duty
);

  localparam int unsigned W  = PWM_COUNTER_BITS;
  localparam int unsigned PW = (BLINK_CYCLE > 1) ? $clog2(BLINK_CYCLE) : 1;
  localparam int unsigned TW = (BREATHE_TICK > 1) ? $clog2(BREATHE_TICK) : 1;
  localparam logic [W-1:0] FULL = W'(PWM_CYCLE);
  localparam logic [W-1:0] STEP = W'(BREATHE_STEP);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic          accept;
  logic          bad_channel;
  logic          cmd_ready_d, cmd_error_d;
  logic          pend_valid_q, pend_valid_d;
  logic [CW-1:0] pend_chan_q, pend_chan_d;
  mode_e         pend_mode_q, pend_mode_d;
  logic [W-1:0]  pend_level_q, pend_level_d;
  logic [W-1:0]  level_sat;

  mode_e         mode_q  [CHANNELS];
  mode_e         mode_d  [CHANNELS];
  logic [PW-1:0] phase_q [CHANNELS];
  logic [PW-1:0] phase_d [CHANNELS];
  logic [TW-1:0] tick_q  [CHANNELS];
  logic [TW-1:0] tick_d  [CHANNELS];
  logic          down_q  [CHANNELS];
  logic          down_d  [CHANNELS];
  logic [W-1:0]  level_q [CHANNELS];
  logic [W-1:0]  level_d [CHANNELS];
  logic [W-1:0]  duty_q  [CHANNELS];
  logic [W-1:0]  duty_d  [CHANNELS];

  assign accept    = cmd_valid & cmd_ready;
  assign level_sat = (cmd_level > FULL) ? FULL : cmd_level;

  // Next-state: command capture, per-channel mode evolution, then pending-command override
  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] res;
    sum          = '0;
    res          = '0;
    cmd_ready_d  = ~accept;
    pend_valid_d = accept;
    pend_chan_d  = pend_chan_q;
    pend_mode_d  = pend_mode_q;
    pend_level_d = pend_level_q;
    if (accept) begin
      pend_chan_d  = cmd_channel;
      pend_mode_d  = mode_e'(cmd_mode);
      pend_level_d = level_sat;
    end
    bad_channel = (32'(pend_chan_q) >= CHANNELS);
    cmd_error_d = pend_valid_q & bad_channel;

    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]  = mode_q[i];
      phase_d[i] = phase_q[i];
      tick_d[i]  = tick_q[i];
      down_d[i]  = down_q[i];
      level_d[i] = level_q[i];
      duty_d[i]  = duty_q[i];
      case (mode_q[i])
        MODE_OFF: duty_d[i] = '0;
        MODE_ON:  duty_d[i] = level_q[i];
        MODE_BLINK: begin
          phase_d[i] = (phase_q[i] == PW'(BLINK_CYCLE - 1)) ? '0 : phase_q[i] + PW'(1);
          duty_d[i]  = (phase_d[i] < PW'(BLINK_ON_COUNT)) ? FULL : '0;
        end
        MODE_BREATHE: begin
          if (tick_q[i] == TW'(BREATHE_TICK - 1)) begin
            tick_d[i] = '0;
            if (!down_q[i]) begin
              // Extra carry bit so a large step can never wrap past the peak
              sum = {1'b0, duty_q[i]} + {1'b0, STEP};
              res = (sum > {1'b0, level_q[i]}) ? level_q[i] : sum[W-1:0];
              if (res == level_q[i]) down_d[i] = 1'b1;
            end else begin
              res = (duty_q[i] <= STEP) ? '0 : duty_q[i] - STEP;
              if (res == '0) down_d[i] = 1'b0;
            end
            duty_d[i] = res;
          end else begin
            tick_d[i] = tick_q[i] + TW'(1);
          end
        end
      endcase

      if (pend_valid_q && !bad_channel && (pend_chan_q == CW'(i))) begin
        mode_d[i]  = pend_mode_q;
        phase_d[i] = '0;
        tick_d[i]  = '0;
        down_d[i]  = 1'b0;
        level_d[i] = pend_level_q;
        case (pend_mode_q)
          MODE_OFF:     duty_d[i] = '0;
          MODE_ON:      duty_d[i] = pend_level_q;
          MODE_BLINK:   duty_d[i] = FULL;
          MODE_BREATHE: duty_d[i] = '0;
        endcase
      end
    end
  end

  // State registers; reset leaves every channel blinking at phase 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready    <= 1'b0;
      cmd_error    <= 1'b0;
      pwm_cycle    <= FULL;
      pend_valid_q <= 1'b0;
      pend_chan_q  <= '0;
      pend_mode_q  <= MODE_OFF;
      pend_level_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_BLINK;
        phase_q[i] <= '0;
        tick_q[i]  <= '0;
        down_q[i]  <= 1'b0;
        level_q[i] <= FULL;
        duty_q[i]  <= FULL;
      end
    end else begin
      cmd_ready    <= cmd_ready_d;
      cmd_error    <= cmd_error_d;
      pwm_cycle    <= FULL;
      pend_valid_q <= pend_valid_d;
      pend_chan_q  <= pend_chan_d;
      pend_mode_q  <= pend_mode_d;
      pend_level_q <= pend_level_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        phase_q[i] <= phase_d[i];
        tick_q[i]  <= tick_d[i];
        down_q[i]  <= down_d[i];
        level_q[i] <= level_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  always_comb begin
    pwm_duty = '0;
    for (int i = 0; i < CHANNELS; i++) pwm_duty[i*W +: W] = duty_q[i];
  end

endmodule

// File: tb/tb_phoenix_led_sequencer.sv
// Directed table-driven bench for phoenix_led_sequencer (4-channel main instance plus a
// 5-channel instance used to reach an out-of-range channel number).
module tb_phoenix_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_channel;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_level;
  logic        cmd_ready, cmd_error;
  logic [15:0] pwm_cycle;
  logic [63:0] pwm_duty;

  logic        v5;
  logic [2:0]  ch5;
  logic [1:0]  mode5;
  logic [15:0] lvl5;
  logic        rdy5, err5;
  logic [15:0] cyc5;
  logic [79:0] duty5;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  phoenix_led_sequencer #(
    .PWM_COUNTER_BITS(16), .CHANNELS(4), .PWM_CYCLE(100), .BLINK_CYCLE(10),
    .BLINK_ON_COUNT(4), .BREATHE_TICK(2), .BREATHE_STEP(25)
  ) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel), .cmd_mode(cmd_mode), .cmd_level(cmd_level),
    .cmd_error(cmd_error), .pwm_cycle(pwm_cycle), .pwm_duty(pwm_duty)
  );

  phoenix_led_sequencer #(
    .PWM_COUNTER_BITS(16), .CHANNELS(5), .PWM_CYCLE(100), .BLINK_CYCLE(10),
    .BLINK_ON_COUNT(4), .BREATHE_TICK(2), .BREATHE_STEP(25)
  ) u_dut5 (
    .clk(clk), .reset(reset), .cmd_valid(v5), .cmd_ready(rdy5),
    .cmd_channel(ch5), .cmd_mode(mode5), .cmd_level(lvl5),
    .cmd_error(err5), .pwm_cycle(cyc5), .pwm_duty(duty5)
  );

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [1:0]  mode;
    logic [15:0] lvl;
    logic        rdy;
    logic        err;
    int          d0, d1, d2, d3;
  } vec_t;

  vec_t tbl [24];

  function automatic int duty(input int c);
    return int'(pwm_duty[c*16 +: 16]);
  endfunction

  function automatic int duty_5(input int c);
    return int'(duty5[c*16 +: 16]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  initial begin
    // Rows: inputs before edge k, expected outputs after edge k (edges counted from release)
    tbl[0]  = '{1'b1, 2'd1, 2'd1, 16'd60,  1'b1, 1'b0, 100, 100, 100, 100};
    tbl[1]  = '{1'b1, 2'd1, 2'd1, 16'd60,  1'b0, 1'b0, 100, 100, 100, 100};
    tbl[2]  = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60, 100, 100};
    tbl[3]  = '{1'b1, 2'd2, 2'd1, 16'd250, 1'b0, 1'b0,   0,  60,   0,   0};
    tbl[4]  = '{1'b1, 2'd2, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60, 100,   0};
    tbl[5]  = '{1'b1, 2'd2, 2'd0, 16'd0,   1'b0, 1'b0,   0,  60, 100,   0};
    tbl[6]  = '{1'b1, 2'd3, 2'd3, 16'd60,  1'b1, 1'b0,   0,  60,   0,   0};
    tbl[7]  = '{1'b1, 2'd3, 2'd3, 16'd60,  1'b0, 1'b0,   0,  60,   0,   0};
    tbl[8]  = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,   0};
    tbl[9]  = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,   0};
    tbl[10] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,  25};
    tbl[11] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,  25};
    tbl[12] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,  50};
    tbl[13] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  50};
    tbl[14] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  60};
    tbl[15] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  60};
    tbl[16] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  35};
    tbl[17] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  35};
    tbl[18] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  10};
    tbl[19] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,  10};
    tbl[20] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,   0};
    tbl[21] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,   0};
    tbl[22] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0, 100,  60,   0,  25};
    tbl[23] = '{1'b0, 2'd0, 2'd0, 16'd0,   1'b1, 1'b0,   0,  60,   0,  25};

    reset = 1'b0;
    cmd_valid = 1'b0; cmd_channel = '0; cmd_mode = '0; cmd_level = '0;
    v5 = 1'b0; ch5 = '0; mode5 = '0; lvl5 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", int'(cmd_ready), 0);
    check("reset error", int'(cmd_error), 0);
    check("reset cycle", int'(pwm_cycle), 100);
    for (int c = 0; c < 4; c++) check($sformatf("reset duty%0d", c), duty(c), 100);

    @(negedge clk);
    reset = 1'b1;
    ecount = 0;

    for (int i = 0; i < 24; i++) begin
      cmd_valid   = tbl[i].v;
      cmd_channel = tbl[i].ch;
      cmd_mode    = tbl[i].mode;
      cmd_level   = tbl[i].lvl;
      step();
      check($sformatf("row%0d ready", i), int'(cmd_ready), int'(tbl[i].rdy));
      check($sformatf("row%0d error", i), int'(cmd_error), int'(tbl[i].err));
      check($sformatf("row%0d duty0", i), duty(0), tbl[i].d0);
      check($sformatf("row%0d duty1", i), duty(1), tbl[i].d1);
      check($sformatf("row%0d duty2", i), duty(2), tbl[i].d2);
      check($sformatf("row%0d duty3", i), duty(3), tbl[i].d3);
    end
    cmd_valid = 1'b0;
    check("run cycle", int'(pwm_cycle), 100);

    // Out-of-range channel on the 5-channel instance: error pulse, duties keep blinking
    v5 = 1'b1; ch5 = 3'd5; mode5 = 2'd1; lvl5 = 16'd7;
    step();
    check("bad accept error", int'(err5), 0);
    check("bad accept ready", int'(rdy5), 0);
    v5 = 1'b0;
    step();
    check("bad error pulse", int'(err5), 1);
    check("bad ready back", int'(rdy5), 1);
    for (int c = 0; c < 5; c++)
      check($sformatf("bad duty%0d", c), duty_5(c), ((ecount % 10) < 4) ? 100 : 0);
    step();
    check("bad error cleared", int'(err5), 0);

    // Reset while ch3 breathes and a command sits in the pending slot
    cmd_valid = 1'b1; cmd_channel = 2'd3; cmd_mode = 2'd1; cmd_level = 16'd30;
    step();
    check("pend accept ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async ready", int'(cmd_ready), 0);
    check("async error", int'(cmd_error), 0);
    check("async cycle", int'(pwm_cycle), 100);
    for (int c = 0; c < 4; c++) check($sformatf("async duty%0d", c), duty(c), 100);
    check("async ready5", int'(rdy5), 0);
    @(negedge clk);
    reset = 1'b1;
    ecount = 0;
    step();
    check("rel ready", int'(cmd_ready), 1);
    check("rel ch3 not pending", duty(3), 100);
    repeat (3) step();
    check("rel ch3 blink e4", duty(3), 0);
    check("rel ch0 blink e4", duty(0), 0);

    // Re-applying BLINK restarts the phase of that channel only
    cmd_valid = 1'b1; cmd_channel = 2'd0; cmd_mode = 2'd2; cmd_level = 16'd0;
    step();
    check("reblink accept duty0", duty(0), 0);
    cmd_valid = 1'b0;
    step();
    check("reblink duty0", duty(0), 100);
    check("reblink duty1", duty(1), 0);
    repeat (4) step();
    check("reblink later duty0", duty(0), 0);
    check("reblink later duty1", duty(1), 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
